// File: rtl/svc_rv_fwd_multi.sv
// ID-stage operand forwarding and hazard detection for NPORTS read ports.
// Optional hazard-cycle counter: define SVC_RV_FWD_HAZ_CNT_EN.
module svc_rv_fwd_multi #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NPORTS   = 2,
   parameter int unsigned MEM_TYPE = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NPORTS*5-1:0]      rs_id,
   input  logic [NPORTS*XLEN-1:0]   rs_data_id,
   input  logic [4:0]               rd_mem,
   input  logic                     reg_write_mem,
   input  logic [2:0]               res_src_mem,
   input  logic [XLEN-1:0]          result_mem,
   input  logic [XLEN-1:0]          load_data_mem,
   input  logic                     load_valid_mem,
   input  logic [4:0]               rd_wb,
   input  logic                     reg_write_wb,
   input  logic [XLEN-1:0]          rd_data_wb,
   output logic [NPORTS*XLEN-1:0]   fwd_rs_id,
   output logic [NPORTS-1:0]        hazard_id,
   output logic [31:0]              hazard_cycles
);

   localparam logic [2:0] RES_ALU  = 3'd0;
   localparam logic [2:0] RES_LOAD = 3'd1;
   localparam logic [2:0] RES_PC4  = 3'd2;
   localparam logic [2:0] RES_IMM  = 3'd3;

   logic            w_hist_valid;
   logic [4:0]      w_hist_rd;
   logic [XLEN-1:0] w_hist_data;

   // A BRAM regfile returns data sampled a cycle earlier, so the write retired
   // in that cycle is replayed from here; it updates even while ID stalls.
   if (MEM_TYPE == 1) begin : g_hist
      logic            r_hist_valid;
      logic [4:0]      r_hist_rd;
      logic [XLEN-1:0] r_hist_data;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_hist_valid <= 1'b0;
            r_hist_rd    <= '0;
            r_hist_data  <= '0;
         end else begin
            r_hist_valid <= reg_write_wb && (rd_wb != 5'd0);
            r_hist_rd    <= rd_wb;
            r_hist_data  <= rd_data_wb;
         end
      end

      assign w_hist_valid = r_hist_valid;
      assign w_hist_rd    = r_hist_rd;
      assign w_hist_data  = r_hist_data;
   end else begin : g_no_hist
      logic w_unused_clk;
      assign w_unused_clk = clk ^ rst_n;
      assign w_hist_valid = 1'b0;
      assign w_hist_rd    = '0;
      assign w_hist_data  = '0;
   end

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      logic [4:0]      w_rs;
      logic [XLEN-1:0] w_rf;
      logic            w_mem_hit;
      logic            w_wb_hit;
      logic            w_hist_hit;
      logic [XLEN-1:0] w_fwd;
      logic            w_haz;

      assign w_rs       = rs_id[p*5 +: 5];
      assign w_rf       = rs_data_id[p*XLEN +: XLEN];
      assign w_mem_hit  = reg_write_mem && (rd_mem == w_rs) && (w_rs != 5'd0);
      assign w_wb_hit   = reg_write_wb  && (rd_wb  == w_rs) && (w_rs != 5'd0);
      assign w_hist_hit = w_hist_valid  && (w_hist_rd == w_rs) && (w_rs != 5'd0);

      // A stalled MEM match keeps the regfile value; WB/history must not
      // sneak a stale value in underneath it.
      always_comb begin
         w_fwd = w_rf;
         w_haz = 1'b0;
         if (w_mem_hit) begin
            case (res_src_mem)
               RES_ALU, RES_PC4, RES_IMM: w_fwd = result_mem;
               RES_LOAD: begin
                  if (load_valid_mem) w_fwd = load_data_mem;
                  else                w_haz = 1'b1;
               end
               default: w_haz = 1'b1;
            endcase
         end else if (w_wb_hit) begin
            w_fwd = rd_data_wb;
         end else if (w_hist_hit) begin
            w_fwd = w_hist_data;
         end
      end

      assign fwd_rs_id[p*XLEN +: XLEN] = w_fwd;
      assign hazard_id[p]              = w_haz;
   end

`ifdef SVC_RV_FWD_HAZ_CNT_EN
   logic [31:0] r_haz_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_haz_cnt <= '0;
      end else if ((|hazard_id) && (r_haz_cnt != '1)) begin
         r_haz_cnt <= r_haz_cnt + 32'd1;
      end
   end

   assign hazard_cycles = r_haz_cnt;
`else
   assign hazard_cycles = '0;
`endif

endmodule

// File: tb/tb_svc_rv_fwd_multi.sv
// Scoreboard bench for svc_rv_fwd_multi: one async-regfile and one BRAM
// (history) instance share stimulus and are checked every cycle.
module tb_svc_rv_fwd_multi;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rs_id;
   logic [63:0] rs_data_id;
   logic [4:0]  rd_mem;
   logic        reg_write_mem;
   logic [2:0]  res_src_mem;
   logic [31:0] result_mem;
   logic [31:0] load_data_mem;
   logic        load_valid_mem;
   logic [4:0]  rd_wb;
   logic        reg_write_wb;
   logic [31:0] rd_data_wb;
   logic [63:0] fwd_a, fwd_s;
   logic [1:0]  haz_a, haz_s;
   logic [31:0] cnt_a, cnt_s;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [31:0] exp_cnt = '0;

`ifdef SVC_RV_FWD_HAZ_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic [4:0]  rs0, rs1;
      logic [31:0] rf0, rf1;
      logic        mwe;
      logic [4:0]  mrd;
      logic [2:0]  msrc;
      logic [31:0] mres, mld;
      logic        mlv;
      logic        wwe;
      logic [4:0]  wrd;
      logic [31:0] wd;
   } vec_t;

   typedef struct {
      string       name;
      logic [63:0] fa;
      logic [1:0]  ha;
      logic [63:0] fs;
      logic [1:0]  hs;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   svc_rv_fwd_multi #(.XLEN(32), .NPORTS(2), .MEM_TYPE(0)) u_dut_async (
      .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rs_data_id(rs_data_id),
      .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .res_src_mem(res_src_mem),
      .result_mem(result_mem), .load_data_mem(load_data_mem),
      .load_valid_mem(load_valid_mem), .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
      .rd_data_wb(rd_data_wb), .fwd_rs_id(fwd_a), .hazard_id(haz_a),
      .hazard_cycles(cnt_a)
   );

   svc_rv_fwd_multi #(.XLEN(32), .NPORTS(2), .MEM_TYPE(1)) u_dut_sync (
      .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rs_data_id(rs_data_id),
      .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .res_src_mem(res_src_mem),
      .result_mem(result_mem), .load_data_mem(load_data_mem),
      .load_valid_mem(load_valid_mem), .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
      .rd_data_wb(rd_data_wb), .fwd_rs_id(fwd_s), .hazard_id(haz_s),
      .hazard_cycles(cnt_s)
   );

   function automatic vec_t mk(input logic [4:0] rs0, input logic [4:0] rs1,
                               input logic [31:0] rf0, input logic [31:0] rf1,
                               input logic mwe, input logic [4:0] mrd,
                               input logic [2:0] msrc, input logic [31:0] mres,
                               input logic [31:0] mld, input logic mlv,
                               input logic wwe, input logic [4:0] wrd,
                               input logic [31:0] wd);
      vec_t v;
      v.rst = 1'b1; v.rs0 = rs0; v.rs1 = rs1; v.rf0 = rf0; v.rf1 = rf1;
      v.mwe = mwe; v.mrd = mrd; v.msrc = msrc; v.mres = mres; v.mld = mld;
      v.mlv = mlv; v.wwe = wwe; v.wrd = wrd; v.wd = wd;
      return v;
   endfunction

   function automatic exp_t ex(input string name, input logic [63:0] fa,
                               input logic [1:0] ha, input logic [63:0] fs,
                               input logic [1:0] hs);
      exp_t e;
      e.name = name; e.fa = fa; e.ha = ha; e.fs = fs; e.hs = hs;
      return e;
   endfunction

   task automatic drive(input vec_t v);
      rst_n          = v.rst;
      rs_id          = {v.rs1, v.rs0};
      rs_data_id     = {v.rf1, v.rf0};
      reg_write_mem  = v.mwe;
      rd_mem         = v.mrd;
      res_src_mem    = v.msrc;
      result_mem     = v.mres;
      load_data_mem  = v.mld;
      load_valid_mem = v.mlv;
      reg_write_wb   = v.wwe;
      rd_wb          = v.wrd;
      rd_data_wb     = v.wd;
   endtask

   localparam logic [31:0] RA = 32'hAAAAAAAA;
   localparam logic [31:0] RB = 32'hBBBBBBBB;

   task automatic test_reset();
      vec_t v;
      exp_t e;
      v = mk(5'd10, 5'd2, RA, RB, 1'b0, 5'd0, 3'd0, '0, '0, 1'b0, 1'b0, 5'd0, '0);
      v.rst = 1'b0;
      drive(v);
      sb.push_back(ex("reset", {RB, RA}, 2'b00, {RB, RA}, 2'b00));
      exp_cnt = '0;
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({fwd_a, haz_a} !== {e.fa, e.ha}) begin
         miscompares++;
         $display("FAIL %s async: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, fwd_a, haz_a, e.fa, e.ha);
      end
      vectors++;
      if ({fwd_s, haz_s} !== {e.fs, e.hs}) begin
         miscompares++;
         $display("FAIL %s sync: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, fwd_s, haz_s, e.fs, e.hs);
      end
      vectors++;
      if ({cnt_a, cnt_s} !== {32'd0, 32'd0}) begin
         miscompares++;
         $display("FAIL %s count: got %0d/%0d want 0", e.name, cnt_a, cnt_s);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_fwd_priority();
      vec_t tv[5];
      exp_t te[5];
      exp_t e;
      logic [31:0] wc;
      tv[0] = mk(5'd10, 5'd2, RA, RB, 1'b0, 5'd0, 3'd0, '0, '0, 1'b0, 1'b1, 5'd10, 32'hDEADBEEF);
      te[0] = ex("wb_fwd", {RB, 32'hDEADBEEF}, 2'b00, {RB, 32'hDEADBEEF}, 2'b00);
      tv[1] = mk(5'd10, 5'd2, RA, RB, 1'b0, 5'd0, 3'd0, '0, '0, 1'b0, 1'b0, 5'd0, '0);
      te[1] = ex("hist_after_wb", {RB, RA}, 2'b00, {RB, 32'hDEADBEEF}, 2'b00);
      tv[2] = mk(5'd10, 5'd2, RA, RB, 1'b1, 5'd10, 3'd0, 32'h11110000, '0, 1'b0, 1'b1, 5'd10, 32'h22220000);
      te[2] = ex("mem_over_wb", {RB, 32'h11110000}, 2'b00, {RB, 32'h11110000}, 2'b00);
      tv[3] = mk(5'd10, 5'd10, RA, RB, 1'b1, 5'd10, 3'd2, 32'h33330000, '0, 1'b0, 1'b0, 5'd0, '0);
      te[3] = ex("mem_pc4_over_hist", {2{32'h33330000}}, 2'b00, {2{32'h33330000}}, 2'b00);
      tv[4] = mk(5'd10, 5'd2, RA, RB, 1'b1, 5'd10, 3'd3, 32'h55550000, '0, 1'b0, 1'b1, 5'd2, 32'h44440000);
      te[4] = ex("mem_imm_wb_other", {32'h44440000, 32'h55550000}, 2'b00, {32'h44440000, 32'h55550000}, 2'b00);
      for (int i = 0; i < 5; i++) begin
         drive(tv[i]);
         sb.push_back(te[i]);
         @(negedge clk);
         e = sb.pop_front();
         wc = CNT_EN ? exp_cnt : 32'd0;
         vectors++;
         if ({fwd_a, haz_a} !== {e.fa, e.ha}) begin
            miscompares++;
            $display("FAIL %s async: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, fwd_a, haz_a, e.fa, e.ha);
         end
         vectors++;
         if ({fwd_s, haz_s} !== {e.fs, e.hs}) begin
            miscompares++;
            $display("FAIL %s sync: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, fwd_s, haz_s, e.fs, e.hs);
         end
         vectors++;
         if ({cnt_a, cnt_s} !== {wc, wc}) begin
            miscompares++;
            $display("FAIL %s count: got %0d/%0d want %0d", e.name, cnt_a, cnt_s, wc);
         end
         if (|e.ha) exp_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_csr();
      vec_t tv[6];
      exp_t te[6];
      exp_t e;
      logic [31:0] wc;
      tv[0] = mk(5'd10, 5'd2, RA, RB, 1'b1, 5'd10, 3'd1, 32'h12345678, 32'h5A5A5A5A, 1'b0, 1'b1, 5'd10, 32'h66660000);
      te[0] = ex("load_pending", {RB, RA}, 2'b01, {32'h44440000, RA}, 2'b01);
      tv[1] = mk(5'd10, 5'd2, RA, RB, 1'b1, 5'd10, 3'd1, 32'h12345678, 32'h5A5A5A5A, 1'b1, 1'b0, 5'd0, '0);
      te[1] = ex("load_valid", {RB, 32'h5A5A5A5A}, 2'b00, {RB, 32'h5A5A5A5A}, 2'b00);
      for (int i = 2; i < 5; i++) begin
         tv[i] = mk(5'd10, 5'd10, RA, RB, 1'b1, 5'd10, 3'd4, 32'h0BAD0BAD, '0, 1'b0, 1'b0, 5'd0, '0);
         te[i] = ex("csr_both", {RB, RA}, 2'b11, {RB, RA}, 2'b11);
      end
      tv[5] = mk(5'd10, 5'd2, RA, RB, 1'b1, 5'd10, 3'd5, 32'h0BAD0BAD, '0, 1'b0, 1'b1, 5'd2, 32'h77770000);
      te[5] = ex("bad_src_indep", {32'h77770000, RA}, 2'b01, {32'h77770000, RA}, 2'b01);
      for (int i = 0; i < 6; i++) begin
         drive(tv[i]);
         sb.push_back(te[i]);
         @(negedge clk);
         e = sb.pop_front();
         wc = CNT_EN ? exp_cnt : 32'd0;
         vectors++;
         if ({fwd_a, haz_a} !== {e.fa, e.ha}) begin
            miscompares++;
            $display("FAIL %s async: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, fwd_a, haz_a, e.fa, e.ha);
         end
         vectors++;
         if ({fwd_s, haz_s} !== {e.fs, e.hs}) begin
            miscompares++;
            $display("FAIL %s sync: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, fwd_s, haz_s, e.fs, e.hs);
         end
         vectors++;
         if ({cnt_a, cnt_s} !== {wc, wc}) begin
            miscompares++;
            $display("FAIL %s count: got %0d/%0d want %0d", e.name, cnt_a, cnt_s, wc);
         end
         if (|e.ha) exp_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_history();
      vec_t tv[8];
      exp_t te[8];
      exp_t e;
      logic [31:0] wc;
      tv[0] = mk(5'd3, 5'd4, RA, RB, 1'b0, 5'd0, 3'd0, '0, '0, 1'b0, 1'b1, 5'd7, 32'hCAFEBABE);
      te[0] = ex("hist_write", {RB, RA}, 2'b00, {RB, RA}, 2'b00);
      tv[1] = mk(5'd7, 5'd2, RA, RB, 1'b0, 5'd0, 3'd0, '0, '0, 1'b0, 1'b0, 5'd0, '0);
      te[1] = ex("hist_n1", {RB, RA}, 2'b00, {RB, 32'hCAFEBABE}, 2'b00);
      tv[2] = tv[1];
      te[2] = ex("hist_n2", {RB, RA}, 2'b00, {RB, RA}, 2'b00);
      tv[3] = tv[0];
      te[3] = ex("hist_write2", {RB, RA}, 2'b00, {RB, RA}, 2'b00);
      tv[4] = tv[1];
      tv[4].rst = 1'b0;
      te[4] = ex("hist_reset", {RB, RA}, 2'b00, {RB, RA}, 2'b00);
      tv[5] = mk(5'd3, 5'd4, RA, RB, 1'b0, 5'd0, 3'd0, '0, '0, 1'b0, 1'b1, 5'd7, 32'h11111111);
      te[5] = ex("hist_write3", {RB, RA}, 2'b00, {RB, RA}, 2'b00);
      tv[6] = mk(5'd7, 5'd2, RA, RB, 1'b0, 5'd0, 3'd0, '0, '0, 1'b0, 1'b1, 5'd7, 32'h22222222);
      te[6] = ex("wb_over_hist", {RB, 32'h22222222}, 2'b00, {RB, 32'h22222222}, 2'b00);
      tv[7] = mk(5'd7, 5'd7, RA, RB, 1'b0, 5'd0, 3'd0, '0, '0, 1'b0, 1'b0, 5'd0, '0);
      te[7] = ex("hist_both_ports", {RB, RA}, 2'b00, {2{32'h22222222}}, 2'b00);
      for (int i = 0; i < 8; i++) begin
         drive(tv[i]);
         sb.push_back(te[i]);
         if (!tv[i].rst) exp_cnt = '0;
         @(negedge clk);
         e = sb.pop_front();
         wc = CNT_EN ? exp_cnt : 32'd0;
         vectors++;
         if ({fwd_a, haz_a} !== {e.fa, e.ha}) begin
            miscompares++;
            $display("FAIL %s async: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, fwd_a, haz_a, e.fa, e.ha);
         end
         vectors++;
         if ({fwd_s, haz_s} !== {e.fs, e.hs}) begin
            miscompares++;
            $display("FAIL %s sync: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, fwd_s, haz_s, e.fs, e.hs);
         end
         vectors++;
         if ({cnt_a, cnt_s} !== {wc, wc}) begin
            miscompares++;
            $display("FAIL %s count: got %0d/%0d want %0d", e.name, cnt_a, cnt_s, wc);
         end
         if (tv[i].rst && (|e.ha)) exp_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_x0();
      vec_t tv[3];
      exp_t te[3];
      exp_t e;
      tv[0] = mk(5'd0, 5'd0, '0, '0, 1'b1, 5'd0, 3'd0, 32'h77770000, '0, 1'b0, 1'b1, 5'd0, 32'h99990000);
      te[0] = ex("x0_write", '0, 2'b00, '0, 2'b00);
      tv[1] = mk(5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 3'd0, '0, '0, 1'b0, 1'b0, 5'd0, '0);
      te[1] = ex("x0_no_hist", '0, 2'b00, '0, 2'b00);
      tv[2] = mk(5'd0, 5'd0, 32'h12345678, 32'h87654321, 1'b1, 5'd0, 3'd4, '0, '0, 1'b0, 1'b1, 5'd0, 32'h99990000);
      te[2] = ex("x0_passthru", {32'h87654321, 32'h12345678}, 2'b00, {32'h87654321, 32'h12345678}, 2'b00);
      for (int i = 0; i < 3; i++) begin
         drive(tv[i]);
         sb.push_back(te[i]);
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if ({fwd_a, haz_a} !== {e.fa, e.ha}) begin
            miscompares++;
            $display("FAIL %s async: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, fwd_a, haz_a, e.fa, e.ha);
         end
         vectors++;
         if ({fwd_s, haz_s} !== {e.fs, e.hs}) begin
            miscompares++;
            $display("FAIL %s sync: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, fwd_s, haz_s, e.fs, e.hs);
         end
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [32:0] ref_port(input logic [4:0] rs, input logic [31:0] rf,
                                            input vec_t v, input logic hv,
                                            input logic [4:0] hrd, input logic [31:0] hd,
                                            input logic use_hist);
      if (rs != 5'd0 && v.mwe && v.mrd == rs) begin
         if (v.msrc == 3'd0 || v.msrc == 3'd2 || v.msrc == 3'd3) return {1'b0, v.mres};
         if (v.msrc == 3'd1 && v.mlv) return {1'b0, v.mld};
         return {1'b1, rf};
      end
      if (rs != 5'd0 && v.wwe && v.wrd == rs) return {1'b0, v.wd};
      if (use_hist && hv && hrd == rs && rs != 5'd0) return {1'b0, hd};
      return {1'b0, rf};
   endfunction

   task automatic test_random();
      vec_t v;
      exp_t e;
      logic [32:0] a0, a1, s0, s1;
      logic hv = 1'b0;
      logic [4:0] hrd = '0;
      logic [31:0] hd = '0;
      logic [31:0] wc;
      for (int i = 0; i < 60; i++) begin
         v = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 5)),
                $urandom, $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
         a0 = ref_port(v.rs0, v.rf0, v, hv, hrd, hd, 1'b0);
         a1 = ref_port(v.rs1, v.rf1, v, hv, hrd, hd, 1'b0);
         s0 = ref_port(v.rs0, v.rf0, v, hv, hrd, hd, 1'b1);
         s1 = ref_port(v.rs1, v.rf1, v, hv, hrd, hd, 1'b1);
         drive(v);
         sb.push_back(ex("random", {a1[31:0], a0[31:0]}, {a1[32], a0[32]},
                         {s1[31:0], s0[31:0]}, {s1[32], s0[32]}));
         @(negedge clk);
         e = sb.pop_front();
         wc = CNT_EN ? exp_cnt : 32'd0;
         vectors++;
         if ({fwd_a, haz_a} !== {e.fa, e.ha}) begin
            miscompares++;
            $display("FAIL %s async #%0d: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, i, fwd_a, haz_a, e.fa, e.ha);
         end
         vectors++;
         if ({fwd_s, haz_s} !== {e.fs, e.hs}) begin
            miscompares++;
            $display("FAIL %s sync #%0d: got fwd=%h haz=%b want fwd=%h haz=%b", e.name, i, fwd_s, haz_s, e.fs, e.hs);
         end
         vectors++;
         if ({cnt_a, cnt_s} !== {wc, wc}) begin
            miscompares++;
            $display("FAIL %s count #%0d: got %0d/%0d want %0d", e.name, i, cnt_a, cnt_s, wc);
         end
         if (|e.ha) exp_cnt++;
         hv  = v.wwe && (v.wrd != 5'd0);
         hrd = v.wrd;
         hd  = v.wd;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      drive(mk(5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 3'd0, '0, '0, 1'b0, 1'b0, 5'd0, '0));
      rst_n = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_fwd_priority();
      test_load_csr();
      test_history();
      test_x0();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/svc_rv_fwd_multi.md
# svc_rv_fwd_multi

Parametrised ID-stage operand forwarding and hazard unit for the svc RISC-V pipelines. It serves NPORTS register-file read ports and forwards from MEM and WB. For synchronous-read (BRAM) register files it adds a one-entry retire history register that covers the write-to-read gap. It flags operands that cannot be forwarded yet, such as CSR results and late load data, so the hazard unit can stall ID.

## Interface
- XLEN, 32, datapath width
- NPORTS, 2, number of source-operand read ports (1..4)
- MEM_TYPE, 0, 0 = asynchronous regfile read, 1 = synchronous (BRAM) read with retire history
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rs_id  in  NPORTS*5  source register indices, port p at [p*5 +: 5]
- rs_data_id  in  NPORTS*XLEN  regfile read data aligned with rs_id
- rd_mem  in  5  MEM-stage destination
- reg_write_mem  in  1  MEM-stage writes rd_mem
- res_src_mem  in  3  MEM result source: 0 ALU, 1 load, 2 PC+4, 3 immediate, 4 CSR
- result_mem  in  XLEN  MEM-stage non-load result
- load_data_mem  in  XLEN  load data
- load_valid_mem  in  1  load_data_mem is valid this cycle
- rd_wb  in  5  WB destination
- reg_write_wb  in  1  WB writes rd_wb
- rd_data_wb  in  XLEN  WB write data
- fwd_rs_id  out  NPORTS*XLEN  forwarded operands, same packing as rs_data_id
- hazard_id  out  NPORTS  per-port: operand not yet available, ID must stall
- hazard_cycles  out  32  saturating count of cycles with any hazard (see Configuration)

## Operation
- A port matches a source when the source's write enable is 1, its rd equals rs_id[p], and rs_id[p] is nonzero. x0 never matches and is always passed through from rs_data_id.
- Per-port priority: MEM, then WB, then history (MEM_TYPE=1 only), then rs_data_id.
- MEM match, res_src_mem = 0/2/3: forward result_mem, no hazard.
- MEM match, res_src_mem = 1, load_valid_mem = 1: forward load_data_mem.
- MEM match, res_src_mem = 1, load_valid_mem = 0: hazard_id[p] = 1.
- MEM match, res_src_mem = 4, or any other code: hazard_id[p] = 1.
- When hazard_id[p] = 1, fwd_rs_id[p] = rs_data_id[p], and lower-priority sources do not override it.
- History register (MEM_TYPE=1):
  - Every clock edge: hist_valid <= reg_write_wb && rd_wb != 0, hist_rd <= rd_wb, hist_data <= rd_data_wb.
  - The register updates unconditionally, including during stalls.
  - Reason: a BRAM read returns data sampled one cycle earlier, so it misses the write retired in that cycle.
- MEM_TYPE=0: no history state. The regfile is assumed write-before-read within a cycle only via WB forwarding.
- Ports are fully independent. All ports may match the same source simultaneously.

## Timing
- fwd_rs_id and hazard_id are combinational from current inputs and the history register. There is zero-cycle latency and no handshake.
- History register latency: one cycle. A write retired in WB at cycle N forwards at cycle N+1 only.
- Reset: hist_valid = 0, hist_rd = 0, hist_data = 0, hazard_cycles = 0. Outputs equal rs_data_id while no source is asserted.
- Reset asserted mid-operation clears the history immediately (asynchronous). Forwarding from MEM/WB continues combinationally from inputs.
- Simultaneous MEM and WB match on the same port: MEM wins. The same applies to WB vs history.
- A hazard on one port does not affect other ports' forwarding.

## Configuration
- SVC_RV_FWD_HAZ_CNT_EN defined:
  - hazard_cycles increments on each clock edge where |hazard_id.
  - It saturates at 32'hFFFFFFFF.
  - It clears on reset.
- Undefined: hazard_cycles is tied to 0 and no counter flops are built.

## Test plan
- NPORTS=2, rs=(10,2), WB rd=10 data DEADBEEF, regfile AAAAAAAA/BBBBBBBB -> fwd=(DEADBEEF, BBBBBBBB), hazard=00.
- MEM rd=10 res_src=0 result 11110000 and WB rd=10 data 22220000, rs1=10 -> fwd rs1 11110000.
- MEM rd=10 res_src=1: with load_valid=0 -> hazard[0]=1 and fwd=AAAAAAAA; next cycle load_valid=1 with load data 5A5A5A5A -> fwd 5A5A5A5A and hazard 0.
- MEM rd=10 res_src=4 on both ports rs=10 -> hazard=11, outputs pass through; with macro enabled, hazard_cycles counts 3 after 3 cycles.
- MEM_TYPE=1: WB rd=7 data CAFEBABE at cycle N, then inputs idle at N+1 with rs1=7 -> fwd CAFEBABE. At N+2 -> regfile data. Asserting rst_n=0 at N+1 -> passthrough.
- rs=0 with WB rd=0 write 99990000 -> fwd 0, history stays invalid.
